imem_boot: RTL and testbench
============================

# imem_boot

Parameterised instruction memory with a built-in boot loader, for the 16-bit CPU fetch stage. After reset it walks the whole array and writes a fill word into every entry. It then accepts a program image word-by-word over a valid/ready stream. Once loaded, it serves registered, byte- or word-addressed instruction fetches with alignment and range checking.

## Interface
- `DATA_W`, 16, instruction word width.
- `ADDR_W`, 16, fetch address width.
- `DEPTH`, 256, number of words; must be ≥2 and ≤ 2^(ADDR_W−BYTE_ADDR).
- `BYTE_ADDR`, 1, 1 = `fetch_addr` is a byte address (word index = `fetch_addr>>1`); 0 = word address.
- `FILL_WORD`, 16'h0000, value written during clear and returned on fetch errors.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `load_valid`  in  1  load stream word present.
- `load_data`  in  `DATA_W`  program word.
- `load_last`  in  1  marks the final word of the image.
- `load_ready`  out  1  loader accepting; high only in LOAD.
- `reload`  in  1  single-cycle request: RUN → CLEAR.
- `fetch_en`  in  1  fetch request; honoured only in RUN.
- `fetch_addr`  in  `ADDR_W`  fetch address.
- `fetch_data`  out  `DATA_W`  registered instruction.
- `fetch_valid`  out  1  `fetch_data` updated by the previous-cycle request.
- `fetch_err`  out  1  previous-cycle request was misaligned or out of range.
- `boot_done`  out  1  state == RUN.
- `load_count`  out  clog2(`DEPTH`+1)  words accepted in the current load.
- `load_trunc`  out  1  sticky; image hit `DEPTH` words without `load_last`.

## Operation
The state machine has three states: CLEAR, LOAD and RUN. Reset state is CLEAR.

- **CLEAR**
  - Each cycle, write `FILL_WORD` to `mem[clr_idx]` and increment `clr_idx`.
  - After writing index `DEPTH`−1, go to LOAD.
  - `load_ready` = 0. Fetches are ignored.
- **LOAD**
  - `load_ready` = 1.
  - On each edge with `load_valid` && `load_ready`, write `load_data` to `mem[load_count]` and increment `load_count`.
  - An accepted word with `load_last` = 1 goes to RUN.
  - An accepted word at index `DEPTH`−1 with `load_last` = 0 goes to RUN and sets `load_trunc`.
  - `load_valid` low holds the state; gaps of any length are legal.
- **RUN**
  - On `fetch_en`, compute word index `idx`.
  - If `BYTE_ADDR` and `fetch_addr[0]` = 1, or if `idx` ≥ `DEPTH`, the request is an error: `fetch_data` ← `FILL_WORD`, `fetch_err` ← 1, and memory is not read.
  - Otherwise `fetch_data` ← `mem[idx]` and `fetch_err` ← 0.
  - In both cases `fetch_valid` ← 1.
  - When `fetch_en` = 0: `fetch_valid` ← 0, `fetch_err` ← 0, `fetch_data` holds.
  - `reload` = 1 goes to CLEAR. `load_count` and `load_trunc` are cleared on entry to CLEAR, not on the request.
- The load stream has no path to memory outside LOAD; `load_valid` in CLEAR or RUN is ignored.
- `reload` outside RUN is ignored.
- `fetch_en` outside RUN is ignored: `fetch_valid` = 0 and `fetch_data` holds.

## Timing
- **Reset values:** `fetch_data` = `FILL_WORD`; `fetch_valid`, `fetch_err`, `boot_done`, `load_ready`, `load_trunc` = 0; `load_count` = 0; `clr_idx` = 0.
- **Clear duration:** exactly `DEPTH` cycles. `load_ready` rises on the `DEPTH`-th rising edge after the last edge with `rst` high.
- **Load to fetch:** the edge that accepts the last word makes `boot_done` = 1. A fetch presented in the following cycle may read that last word.
- **Fetch latency:** 1 cycle. A request sampled at edge N appears on `fetch_data`/`fetch_valid`/`fetch_err` after edge N. Back-to-back requests give one result per cycle.
- **Reload:** a `reload` and a `fetch_en` in the same cycle both complete. The fetch result is registered and the state becomes CLEAR. Fetches are then ignored.
- **Mid-operation reset:** `rst` in any state (mid-clear, mid-load, mid-fetch) restores all reset values on that edge, overriding all other inputs, and restarts CLEAR from index 0.
- **Port widths:** `load_count` saturates at `DEPTH`. `idx` is computed at `ADDR_W` width with no truncation before the range compare.

## Test plan
- **Clear timing:** `DEPTH`=256, deassert `rst`. Require `load_ready` = 0 for 255 cycles and `load_ready` = 1 on cycle 256. Load 1 word with `load_last`, then fetch 0x0002 → `fetch_data` = 0x0000, `fetch_err` = 0.
- **Load and fetch:** stream 0x1120, 0x11D1, 0x148E (last), with one idle gap between the 2nd and 3rd word. Require `boot_done` one edge after the third word, `load_count` = 3. Fetch 0x0000, 0x0002, 0x0004 back-to-back → 0x1120, 0x11D1, 0x148E with `fetch_valid` = 1 on each following cycle.
- **Fetch errors:** in RUN, fetch 0x0003 → `fetch_err` = 1, `fetch_data` = `FILL_WORD`. Fetch 0x0200 with `DEPTH`=256 → `fetch_err` = 1. Idle cycle → `fetch_valid` = 0, `fetch_data` holds.
- **Truncation:** `DEPTH`=4, stream 5 words with no `load_last`. Require words 1–4 stored, RUN entered after the 4th, `load_trunc` = 1, 5th word not accepted (`load_ready` = 0).
- **Mid-load reset:** assert `rst` after 2 words. Require `load_count` = 0, `load_ready` = 0 for `DEPTH` cycles, and previously loaded words read back as `FILL_WORD` after a fresh 1-word load.
- **Reload:** in RUN, pulse `reload` together with a fetch of 0x0000. Require a valid fetch result, then CLEAR. `load_trunc` and `load_count` are cleared and the new image replaces the old.

Source files
------------

// File: rtl/imem_boot.sv
// Instruction memory with boot loader: clears every word to FILL_WORD, accepts a
// program image over a valid/ready stream, then serves registered fetches.
module imem_boot #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DEPTH     = 256,
  parameter int unsigned       BYTE_ADDR = 1,
  parameter logic [DATA_W-1:0] FILL_WORD = '0,
  localparam int unsigned      CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              fetch_err,
  output logic              boot_done,
  output logic [CNT_W-1:0]  load_count,
  output logic              load_trunc
);

  localparam int unsigned      AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]    CLR_LAST = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

  state_t            state;
  logic [AW-1:0]     clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic              fetch_bad;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Word index kept at full address width so out-of-range addresses never alias.
  always_comb begin
    idx       = (BYTE_ADDR != 0) ? (fetch_addr >> 1) : fetch_addr;
    fetch_bad = ((BYTE_ADDR != 0) && fetch_addr[0]) || ({1'b0, idx} >= DEPTH_X);
  end

  // Single write port shared by the clear walk and the loader.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = FILL_WORD;
    if (!rst) begin
      case (state)
        CLEAR: begin
          mem_we    = 1'b1;
          mem_waddr = clr_idx;
        end
        LOAD: begin
          if (load_valid) begin
            mem_we    = 1'b1;
            mem_waddr = AW'(load_count);
            mem_wdata = load_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clr_idx     <= '0;
      load_count  <= '0;
      load_trunc  <= 1'b0;
      load_ready  <= 1'b0;
      boot_done   <= 1'b0;
      fetch_data  <= FILL_WORD;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == CLR_LAST) begin
            clr_idx    <= '0;
            state      <= LOAD;
            load_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (load_valid) begin
            load_count <= load_count + CNT_W'(1);
            // Last accepted word, either flagged or forced by a full array.
            if (load_last || (load_count == CNT_LAST)) begin
              state      <= RUN;
              load_ready <= 1'b0;
              boot_done  <= 1'b1;
              load_trunc <= !load_last;
            end
          end
        end
        RUN: begin
          if (fetch_en) begin
            fetch_valid <= 1'b1;
            if (fetch_bad) begin
              fetch_data <= FILL_WORD;
              fetch_err  <= 1'b1;
            end else begin
              fetch_data <= mem[AW'(idx)];
            end
          end
          if (reload) begin
            state      <= CLEAR;
            clr_idx    <= '0;
            boot_done  <= 1'b0;
            load_count <= '0;
            load_trunc <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot.sv
// Self-checking bench for imem_boot: directed tables, multi-cycle sequences and
// randomized images/fetches checked against an array-based reference model.
module tb_imem_boot;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 256-word instance, FILL_WORD = 0
  logic        rst, lv, ll, reload, fen;
  logic [15:0] ld, faddr, fdata;
  logic        ready, fvalid, ferr, done, trunc;
  logic [8:0]  count;

  imem_boot u_dut (
    .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld), .load_last(ll),
    .load_ready(ready), .reload(reload), .fetch_en(fen), .fetch_addr(faddr),
    .fetch_data(fdata), .fetch_valid(fvalid), .fetch_err(ferr), .boot_done(done),
    .load_count(count), .load_trunc(trunc)
  );

  // 4-word instance with a non-zero fill word
  logic        s_rst, s_lv, s_ll, s_reload, s_fen;
  logic [15:0] s_ld, s_faddr, s_fdata;
  logic        s_ready, s_fvalid, s_ferr, s_done, s_trunc;
  logic [2:0]  s_count;

  imem_boot #(.DEPTH(4), .FILL_WORD(16'hDEAD)) u_small (
    .clk(clk), .rst(s_rst), .load_valid(s_lv), .load_data(s_ld), .load_last(s_ll),
    .load_ready(s_ready), .reload(s_reload), .fetch_en(s_fen), .fetch_addr(s_faddr),
    .fetch_data(s_fdata), .fetch_valid(s_fvalid), .fetch_err(s_ferr), .boot_done(s_done),
    .load_count(s_count), .load_trunc(s_trunc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        en;
    logic [15:0] addr;
    logic [15:0] data;
    logic        valid;
    logic        err;
  } vec_t;

  vec_t        vt [14];
  logic [15:0] model_mem [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic last);
    lv = 1'b1; ld = d; ll = last;
    step();
    lv = 1'b0; ll = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    fen = v.en; faddr = v.addr;
    step();
    fen = 1'b0;
    chk({tag, ".valid"}, fvalid, v.valid);
    chk({tag, ".err"}, ferr, v.err);
    chk({tag, ".data"}, fdata, v.data);
  endtask

  // Exactly 256 edges of clear: ready low on the first 255, high on the 256th.
  task automatic clear_timing(input string tag);
    int early = 0;
    for (int i = 1; i <= 256; i++) begin
      step();
      if (i < 256 && ready) early++;
    end
    chk({tag, ".ready_low"}, early, 0);
    chk({tag, ".ready_rise"}, ready, 1);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 400) begin
      step();
      n++;
    end
    chk({tag, ".ready"}, ready, 1);
    chk({tag, ".clear_cycles"}, n, 256);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  task automatic random_round(input int r);
    int          len;
    logic [15:0] w, a, exp_d;
    logic        en, exp_e;
    do_reload();
    wait_ready($sformatf("rnd%0d", r));
    len = $urandom_range(1, 40);
    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
    for (int i = 0; i < len; i++) begin
      w = 16'($urandom);
      model_mem[i] = w;
      push(w, i == len - 1);
      if (i != len - 1 && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
    end
    chk($sformatf("rnd%0d.done", r), done, 1);
    chk($sformatf("rnd%0d.count", r), count, 32'(len));
    chk($sformatf("rnd%0d.trunc", r), trunc, 0);
    exp_d = 16'h0000;
    for (int k = 0; k < 80; k++) begin
      en = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2 * len + 3));
      lv = 1'($urandom_range(0, 1));
      ld = 16'($urandom);
      fen = en; faddr = a;
      step();
      exp_e = 1'b0;
      if (en) begin
        if (a[0] || (a / 2) >= 256) begin
          exp_d = 16'h0000;
          exp_e = 1'b1;
        end else begin
          exp_d = model_mem[a / 2];
        end
      end
      if (fvalid !== en || ferr !== exp_e || fdata !== exp_d) begin
        chk($sformatf("rnd%0d.fetch%0d addr=%h", r, k, a), {fvalid, ferr, 14'h0, fdata},
            {en, exp_e, 14'h0, exp_d});
      end else begin
        n_cmp++;
      end
    end
    fen = 1'b0; lv = 1'b0;
    // stray load words in RUN must not have been written
    run_vec('{1'b1, 16'(2 * len), 16'h0000, 1'b1, 1'b0}, $sformatf("rnd%0d.past_end", r));
  endtask

  initial begin
    vt[0]  = '{1'b1, 16'h0000, 16'h1120, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 16'h0002, 16'h11D1, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 16'h0004, 16'h148E, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 16'h0004, 16'h148E, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 16'h0003, 16'h0000, 1'b1, 1'b1};
    vt[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 16'h0200, 16'h0000, 1'b1, 1'b1};
    vt[7]  = '{1'b1, 16'h0006, 16'h0000, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 16'h0002, 16'h11D1, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 16'h01FE, 16'h0000, 1'b1, 1'b0};
    vt[10] = '{1'b1, 16'h01FF, 16'h0000, 1'b1, 1'b1};
    vt[11] = '{1'b1, 16'hFFFE, 16'h0000, 1'b1, 1'b1};
    vt[12] = '{1'b1, 16'h0000, 16'h1120, 1'b1, 1'b0};
    vt[13] = '{1'b0, 16'h0002, 16'h1120, 1'b0, 1'b0};

    rst = 1'b1; lv = 1'b0; ll = 1'b0; ld = '0; reload = 1'b0; fen = 1'b0; faddr = '0;
    s_rst = 1'b1; s_lv = 1'b0; s_ll = 1'b0; s_ld = '0; s_reload = 1'b0; s_fen = 1'b0;
    s_faddr = '0;
    step();

    // ---- truncation on the 4-word instance ----
    s_rst = 1'b0;
    begin
      int n = 0;
      while (!s_ready && n < 20) begin
        step();
        n++;
      end
      chk("small.clear_cycles", n, 4);
    end
    for (int i = 0; i < 4; i++) begin
      s_lv = 1'b1; s_ld = 16'(16'h2000 + i);
      step();
      if (i == 2) begin
        chk("small.mid_ready", s_ready, 1);
        chk("small.mid_done", s_done, 0);
      end
    end
    chk("small.done", s_done, 1);
    chk("small.trunc", s_trunc, 1);
    chk("small.count", s_count, 4);
    chk("small.ready_off", s_ready, 0);
    s_ld = 16'h2004;
    step();
    s_lv = 1'b0;
    chk("small.count_after5", s_count, 4);
    chk("small.ready_after5", s_ready, 0);
    for (int i = 0; i < 5; i++) begin
      s_fen = 1'b1; s_faddr = 16'(2 * i);
      step();
      chk($sformatf("small.fetch%0d.data", i), s_fdata, (i < 4) ? 32'(16'h2000 + i) : 32'hDEAD);
      chk($sformatf("small.fetch%0d.err", i), s_ferr, (i < 4) ? 0 : 1);
    end
    s_fen = 1'b0;

    // ---- reset values and clear timing on the 256-word instance ----
    fen = 1'b1; lv = 1'b1;
    step();
    fen = 1'b0; lv = 1'b0;
    chk("rst.fetch_data", fdata, 16'h0000);
    chk("rst.fetch_valid", fvalid, 0);
    chk("rst.fetch_err", ferr, 0);
    chk("rst.boot_done", done, 0);
    chk("rst.load_ready", ready, 0);
    chk("rst.load_trunc", trunc, 0);
    chk("rst.load_count", count, 0);
    rst = 1'b0;
    clear_timing("boot");
    push(16'hABCD, 1'b1);
    chk("boot.done", done, 1);
    chk("boot.count", count, 1);
    chk("boot.ready_off", ready, 0);
    run_vec('{1'b1, 16'h0002, 16'h0000, 1'b1, 1'b0}, "boot.fetch2");

    // ---- reload together with a fetch ----
    fen = 1'b1; faddr = 16'h0000; reload = 1'b1;
    step();
    reload = 1'b0;
    chk("reload.valid", fvalid, 1);
    chk("reload.data", fdata, 16'hABCD);
    chk("reload.done", done, 0);
    chk("reload.count", count, 0);
    wait_ready("reload");
    chk("reload.ignored_valid", fvalid, 0);
    step();
    fen = 1'b0;
    chk("load.ignored_valid", fvalid, 0);
    chk("load.hold_data", fdata, 16'hABCD);

    // ---- three-word image with a gap, then table of fetches ----
    push(16'h1120, 1'b0);
    push(16'h11D1, 1'b0);
    step();
    chk("img.gap_count", count, 2);
    chk("img.gap_done", done, 0);
    push(16'h148E, 1'b1);
    chk("img.done", done, 1);
    chk("img.count", count, 3);
    chk("img.trunc", trunc, 0);
    for (int i = 0; i < 14; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // ---- reset in the middle of a load ----
    do_reload();
    wait_ready("ml");
    push(16'hDEAD, 1'b0);
    push(16'hBEEF, 1'b0);
    chk("ml.count2", count, 2);
    rst = 1'b1;
    lv = 1'b1; ld = 16'h7777;
    step();
    rst = 1'b0; lv = 1'b0;
    chk("ml.count_rst", count, 0);
    chk("ml.ready_rst", ready, 0);
    chk("ml.done_rst", done, 0);
    clear_timing("ml");
    push(16'h5555, 1'b1);
    run_vec('{1'b1, 16'h0000, 16'h5555, 1'b1, 1'b0}, "ml.fetch0");
    run_vec('{1'b1, 16'h0002, 16'h0000, 1'b1, 1'b0}, "ml.fetch2");
    run_vec('{1'b1, 16'h0004, 16'h0000, 1'b1, 1'b0}, "ml.fetch4");

    // ---- randomized images and fetches ----
    for (int r = 0; r < 4; r++) random_round(r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
